escaped_operand_player: RTL and testbench
=========================================

Name: escaped_operand_player

Overview:
- Synthesizable, parametrised successor to the simulation-only operand stimulus driver.
- Accepts an escaped byte stream: 0x7D escape byte, next byte XOR 0x20.
- De-escapes the stream, assembles byte pairs into two WIDTH-bit operands, and presents them to the adder-under-test through a valid/ready handshake.
- Counts delivered operand pairs and stops after LENGTH pairs.

Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of 8 (BYTES = WIDTH/8).
- LENGTH, 1000000: pairs to deliver before done; 0 = unlimited.
- ESC_BYTE, 8'h7D: escape marker.
- ESC_XOR, 8'h20: XOR mask applied to the byte following ESC_BYTE.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-low reset; sampled at posedge.
- in_valid_i  in  1  input byte valid.
- in_data_i  in  8  escaped input byte.
- in_ready_o  out  1  block accepts in_data_i this cycle.
- op_valid_o  out  1  operand pair valid.
- op_a_o  out  WIDTH  operand a.
- op_b_o  out  WIDTH  operand b.
- op_ready_i  in  1  consumer accepts pair.
- count_o  out  32  pairs delivered (handshakes completed).
- done_o  out  1  LENGTH pairs delivered; sticky.
- esc_err_o  out  1  sticky protocol error: ESC_BYTE received while an escape is pending.

Behaviour:
- Reset (reset_i==0 at posedge): state=COLLECT_A, byte index=0, esc_pending=0, op_valid_o=0, op_a_o=0, op_b_o=0, count_o=0, done_o=0, esc_err_o=0. Reset overrides any in-flight handshake; a partially assembled pair is discarded.
- States: COLLECT_A, COLLECT_B, HOLD, DONE.
- in_ready_o=1 only in COLLECT_A/COLLECT_B. A byte is consumed when in_valid_i && in_ready_o.
- Consumed byte, esc_pending=0, byte==ESC_BYTE: set esc_pending; no data produced.
- Consumed byte, esc_pending=1, byte!=ESC_BYTE: data = byte ^ ESC_XOR; clear esc_pending.
- Consumed byte, esc_pending=1, byte==ESC_BYTE: set esc_err_o; byte discarded; esc_pending stays 1.
- Otherwise the byte is data as-is.
- Each data byte fills operand byte [index], LSB first (index 0 -> bits 7:0).
- After byte BYTES-1, index wraps to 0 and state advances COLLECT_A -> COLLECT_B.
- Completing the last b byte: state -> HOLD; op_valid_o=1 on the next cycle. Latency = 1 cycle from final data-byte handshake to op_valid_o.
- HOLD: op_a_o/op_b_o stable while op_valid_o && !op_ready_i.
- On op_ready_i in HOLD: count_o += 1, op_valid_o=0 next cycle.
  - If LENGTH!=0 and the new count==LENGTH: state -> DONE, done_o=1 that same next cycle.
  - Else state -> COLLECT_A.
- Throughput: no bubble overlap; the next pair's first byte is accepted the cycle after the handshake.
- DONE: in_ready_o=0, op_valid_o=0; leave only via reset. count_o saturates at LENGTH; with LENGTH=0 it wraps at 2^32.
- esc_pending persists across operand and pair boundaries: an escape may be the last byte of a and its partner the first byte of b.
- op_ready_i asserted while op_valid_o=0 is ignored.

Optional Feature:
- Macro: PLAYER_BIG_ENDIAN_EN.
- Defined: bytes assembled MSB first (index 0 -> bits WIDTH-1:WIDTH-8).
- Undefined: LSB first as above.
- For WIDTH=8 both modes are identical.

Test Plan:
- WIDTH=16, stream 34 12 78 56 with op_ready_i=1 -> op_a_o=0x1234, op_b_o=0x5678, op_valid_o one cycle after byte 56; count_o=1. With PLAYER_BIG_ENDIAN_EN: op_a_o=0x3412, op_b_o=0x7856.
- WIDTH=8, stream 7D 5D 7D 0D -> op_a_o=0x7D, op_b_o=0x2D; esc_err_o=0.
- WIDTH=8, stream 7D 7D 5D 01 -> esc_err_o=1, op_a_o=0x7D, op_b_o=0x01.
- Backpressure: hold op_ready_i=0 for 5 cycles after op_valid_o -> in_ready_o=0 and outputs stable throughout; the pair is accepted once on release, count_o increments by exactly 1.
- LENGTH=2, four data bytes 01 02 03 04 -> done_o=1 the cycle after the 2nd handshake; further in_valid_i ignored, in_ready_o=0, count_o stays 2.
- Reset mid-pair: send 7D then drive reset_i=0 for one cycle, then send 11 22 -> op_a_o=0x11, op_b_o=0x22 (escape cleared), count_o=1.

Source files
------------

// File: rtl/escaped_operand_player.sv
// escaped_operand_player: de-escapes a byte stream into WIDTH-bit operand pairs and delivers them over valid/ready.
// Define PLAYER_BIG_ENDIAN_EN to assemble operand bytes MSB first instead of LSB first.
module escaped_operand_player #(
    parameter int WIDTH = 8,
    parameter int LENGTH = 1000000,
    parameter logic [7:0] ESC_BYTE = 8'h7D,
    parameter logic [7:0] ESC_XOR = 8'h20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             op_valid_o,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    input  logic             op_ready_i,
    output logic [31:0]      count_o,
    output logic             done_o,
    output logic             esc_err_o
);
    localparam int BYTES = WIDTH / 8;
    localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    typedef enum logic [1:0] {COLLECT_A, COLLECT_B, HOLD, DONE} state_t;

    state_t           state, state_next;
    logic [IW-1:0]    idx, idx_next, pos;
    logic             esc_pending, esc_next, err_next;
    logic [WIDTH-1:0] a_next, b_next;
    logic [31:0]      count_next;
    logic             take, is_esc;
    logic [7:0]       data;

    assign in_ready_o = state == COLLECT_A || state == COLLECT_B;
    assign op_valid_o = state == HOLD;
    assign done_o     = state == DONE;
    assign take       = in_valid_i && in_ready_o;
    assign is_esc     = in_data_i == ESC_BYTE;
    assign data       = esc_pending ? in_data_i ^ ESC_XOR : in_data_i;
`ifdef PLAYER_BIG_ENDIAN_EN
    assign pos = LAST - idx;
`else
    assign pos = idx;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        esc_next   = esc_pending;
        err_next   = esc_err_o;
        a_next     = op_a_o;
        b_next     = op_b_o;
        count_next = count_o;
        if (take && is_esc) begin
            esc_next = 1'b1;
            err_next = esc_err_o | esc_pending;
        end else if (take) begin
            esc_next = 1'b0;
            if (state == COLLECT_A) a_next[{pos, 3'b000} +: 8] = data;
            else b_next[{pos, 3'b000} +: 8] = data;
            idx_next = idx == LAST ? '0 : idx + IW'(1);
            if (idx == LAST) state_next = state == COLLECT_A ? COLLECT_B : HOLD;
        end
        if (state == HOLD && op_ready_i) begin
            count_next = count_o + 32'd1;
            state_next = (LENGTH != 0 && count_next == 32'(LENGTH)) ? DONE : COLLECT_A;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state       <= COLLECT_A;
            idx         <= '0;
            esc_pending <= 1'b0;
            esc_err_o   <= 1'b0;
            op_a_o      <= '0;
            op_b_o      <= '0;
            count_o     <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            esc_pending <= esc_next;
            esc_err_o   <= err_next;
            op_a_o      <= a_next;
            op_b_o      <= b_next;
            count_o     <= count_next;
        end
    end
endmodule

// File: tb/tb_escaped_operand_player.sv
// tb_escaped_operand_player: directed checks on a 16-bit unlimited player (a) and an 8-bit LENGTH=2 player (b).
module tb_escaped_operand_player;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_valid, a_ready, a_in_ready, a_op_valid, a_done, a_err;
    logic [7:0]  a_data;
    logic [15:0] a_op_a, a_op_b;
    logic [31:0] a_count;
    logic        b_rst, b_valid, b_ready, b_in_ready, b_op_valid, b_done, b_err;
    logic [7:0]  b_data, b_op_a, b_op_b;
    logic [31:0] b_count;
    int checks = 0, errors = 0;

    escaped_operand_player #(.WIDTH(16), .LENGTH(0)) dut_a (
        .clk_i(clk), .reset_i(a_rst), .in_valid_i(a_valid), .in_data_i(a_data),
        .in_ready_o(a_in_ready), .op_valid_o(a_op_valid), .op_a_o(a_op_a), .op_b_o(a_op_b),
        .op_ready_i(a_ready), .count_o(a_count), .done_o(a_done), .esc_err_o(a_err));

    escaped_operand_player #(.WIDTH(8), .LENGTH(2)) dut_b (
        .clk_i(clk), .reset_i(b_rst), .in_valid_i(b_valid), .in_data_i(b_data),
        .in_ready_o(b_in_ready), .op_valid_o(b_op_valid), .op_a_o(b_op_a), .op_b_o(b_op_b),
        .op_ready_i(b_ready), .count_o(b_count), .done_o(b_done), .esc_err_o(b_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] d);
        a_valid = 1'b1;
        a_data = d;
        step();
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d);
        b_valid = 1'b1;
        b_data = d;
        step();
        b_valid = 1'b0;
    endtask

    initial begin
        a_rst = 0; a_valid = 0; a_ready = 0; a_data = 0;
        b_rst = 0; b_valid = 0; b_ready = 0; b_data = 0;
        step();
        step();
        chk("rst_a_valid", 32'(a_op_valid), 0);
        chk("rst_a_ops", {a_op_a, a_op_b}, 0);
        chk("rst_a_count", a_count, 0);
        chk("rst_a_flags", {a_done, a_err, a_in_ready}, 3'b001);
        chk("rst_b_flags", {b_done, b_err, b_in_ready, b_op_valid}, 4'b0010);
        a_rst = 1; b_rst = 1;

        a_ready = 1;
        a_send(8'h34); a_send(8'h12); a_send(8'h78);
        chk("lat_before_last", 32'(a_op_valid), 0);
        a_send(8'h56);
        chk("basic_valid", 32'(a_op_valid), 1);
        chk("basic_a", 32'(a_op_a), 32'h1234);
        chk("basic_b", 32'(a_op_b), 32'h5678);
        chk("basic_count_pre", a_count, 0);
        step();
        chk("basic_count", a_count, 1);
        chk("basic_after", {a_op_valid, a_in_ready}, 2'b01);

        a_ready = 0;
        a_send(8'hAA); a_send(8'hBB); a_send(8'hCC); a_send(8'hDD);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(a_in_ready), 0);
            chk("bp_valid", 32'(a_op_valid), 1);
            chk("bp_ops", {a_op_a, a_op_b}, 32'hBBAADDCC);
            chk("bp_count", a_count, 1);
            step();
        end
        a_ready = 1;
        step();
        chk("bp_release_count", a_count, 2);
        chk("bp_release_valid", 32'(a_op_valid), 0);
        step();
        chk("ready_idle_ignored", a_count, 2);

        a_send(8'h7D);
        a_rst = 0;
        step();
        chk("midrst_count", a_count, 0);
        chk("midrst_valid", 32'(a_op_valid), 0);
        a_rst = 1;
        a_send(8'h11); a_send(8'h00); a_send(8'h22); a_send(8'h00);
        chk("midrst_ops", {a_op_a, a_op_b}, 32'h00110022);
        step();
        chk("midrst_count_after", a_count, 1);
        chk("midrst_err", 32'(a_err), 0);

        b_send(8'h7D); b_send(8'h5D); b_send(8'h7D); b_send(8'h0D);
        chk("esc_valid", 32'(b_op_valid), 1);
        chk("esc_ops", {b_op_a, b_op_b}, 16'h7D2D);
        chk("esc_err", 32'(b_err), 0);
        b_ready = 1;
        step();
        chk("esc_count", b_count, 1);
        b_ready = 0;
        b_rst = 0;
        step();
        b_rst = 1;
        b_send(8'h7D); b_send(8'h7D);
        chk("dbl_esc_err", 32'(b_err), 1);
        b_send(8'h5D); b_send(8'h01);
        chk("dbl_esc_ops", {b_op_a, b_op_b}, 16'h7D01);
        chk("dbl_esc_valid", 32'(b_op_valid), 1);
        b_rst = 0;
        step();
        b_rst = 1;
        chk("err_cleared", 32'(b_err), 0);

        b_ready = 1;
        b_send(8'h01); b_send(8'h02);
        chk("len_ops1", {b_op_a, b_op_b}, 16'h0102);
        step();
        chk("len_count1", b_count, 1);
        chk("len_done1", 32'(b_done), 0);
        b_send(8'h03); b_send(8'h04);
        chk("len_ops2", {b_op_a, b_op_b}, 16'h0304);
        step();
        chk("len_count2", b_count, 2);
        chk("len_done", {b_done, b_in_ready, b_op_valid}, 3'b100);
        b_valid = 1; b_data = 8'h55;
        repeat (3) step();
        b_valid = 0;
        chk("done_count_hold", b_count, 2);
        chk("done_sticky", {b_done, b_in_ready, b_op_valid}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
